rv3n_dmem_arb: RTL and testbench

Two-master arbiter that shares the single data-memory port (dmem_*) between the load/store unit (master 0) and a secondary master (master 1, e.g. debug or DMA).
- Issues at most one request per cycle to memory.
- Tracks up to DEPTH outstanding transactions in an in-order tag FIFO and routes each dmem_resp, its rdata and its err back to the issuing master.
- Sits between the LSU and the memory-side interconnect.
- Adds zero latency to both the request and the response path.

---
 rtl/rv3n_dmem_arb_pkg.sv | 26 ++
 rtl/rv3n_arb_tagfifo.sv | 49 ++++
 rtl/rv3n_dmem_arb.sv | 120 ++++++++++++
 tb/tb_rv3n_dmem_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv3n_dmem_arb_pkg.sv
// Shared types and constants for the rv3n data-memory arbiter.
// Master IDs, bus command/width encodings and the request bundle.
package rv3n_dmem_arb_pkg;

    localparam int XLEN = 32;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    typedef enum logic {
        MST0 = 1'b0,
        MST1 = 1'b1
    } mst_t;

    typedef struct packed {
        logic            cmd;
        logic [1:0]      width;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dreq_t;

endpackage

// File: rtl/rv3n_arb_tagfifo.sv
// In-order FIFO of master IDs for outstanding memory transactions.
// Push and pop may happen in the same cycle, even when full.
module rv3n_arb_tagfifo
    import rv3n_dmem_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  mst_t          push_id,
    input  logic          pop,
    output mst_t          head,
    output logic [CW-1:0] count
);

    mst_t          mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= nxt(wp);
            if (pop)  rp <= nxt(rp);
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

    // Tag storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= push_id;
    end

    assign head = mem[rp];

endmodule

// File: rtl/rv3n_dmem_arb.sv
// Two-master arbiter for the shared dmem port, zero added latency.
// Responses return in order and are steered by a tag FIFO.
module rv3n_dmem_arb
    import rv3n_dmem_arb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter bit FIXED_PRIO = 1'b0,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic            m0_cmd,
    input  logic [1:0]      m0_width,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    output logic            m0_gnt,
    output logic            m0_resp,
    output logic [XLEN-1:0] m0_rdata,
    output logic            m0_err,
    input  logic            m1_req,
    input  logic            m1_cmd,
    input  logic [1:0]      m1_width,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    output logic            m1_gnt,
    output logic            m1_resp,
    output logic [XLEN-1:0] m1_rdata,
    output logic            m1_err,
    output logic            dmem_req,
    output logic            dmem_cmd,
    output logic [1:0]      dmem_width,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_resp,
    input  logic            dmem_err,
    output logic            arb_busy,
    output logic            arb_spurious
);

    logic [CW-1:0] count;
    mst_t          head;
    mst_t          winner;
    mst_t          last_gnt;
    logic          nonempty;
    logic          pop;
    logic          space;
    dreq_t         sel;

    assign nonempty = (count != '0);
    assign pop      = dmem_resp & nonempty;
    // A full FIFO can still accept when a response frees a slot now.
    assign space    = (count < CW'(DEPTH)) | pop;
    assign dmem_req = (m0_req | m1_req) & space;

    always_comb begin
        winner = MST0;
        unique case (1'b1)
            (m0_req & m1_req):
                winner = FIXED_PRIO ? MST0 :
                         ((last_gnt == MST0) ? MST1 : MST0);
            (m1_req & !m0_req):
                winner = MST1;
            default:
                winner = MST0;
        endcase
    end

    assign m0_gnt = dmem_req & (winner == MST0);
    assign m1_gnt = dmem_req & (winner == MST1);

    always_comb begin
        sel = '0;
        if (dmem_req) begin
            if (winner == MST1)
                sel = '{m1_cmd, m1_width, m1_addr, m1_wdata};
            else
                sel = '{m0_cmd, m0_width, m0_addr, m0_wdata};
        end
    end

    assign dmem_cmd   = sel.cmd;
    assign dmem_width = sel.width;
    assign dmem_addr  = sel.addr;
    assign dmem_wdata = sel.wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt     <= MST1;
            arb_spurious <= 1'b0;
        end else begin
            if (dmem_req)
                last_gnt <= winner;
            if (dmem_resp && !nonempty)
                arb_spurious <= 1'b1;
        end
    end

    rv3n_arb_tagfifo #(
        .DEPTH (DEPTH)
    ) u_tagfifo (
        .clk     (clk),
        .rst     (rst),
        .push    (dmem_req),
        .push_id (winner),
        .pop     (pop),
        .head    (head),
        .count   (count)
    );

    assign m0_resp  = pop & (head == MST0);
    assign m1_resp  = pop & (head == MST1);
    assign m0_rdata = m0_resp ? dmem_rdata : '0;
    assign m1_rdata = m1_resp ? dmem_rdata : '0;
    assign m0_err   = m0_resp & dmem_err;
    assign m1_err   = m1_resp & dmem_err;
    assign arb_busy = nonempty;

endmodule

// File: tb/tb_rv3n_dmem_arb.sv
// Randomized scoreboard bench for rv3n_dmem_arb against a queue model.
// Directed phases cover ordering, stalls, errors, spurious and reset.
module tb_rv3n_dmem_arb;
    import rv3n_dmem_arb_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_cmd, m0_gnt, m0_resp, m0_err;
    logic [1:0]  m0_width;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_cmd, m1_gnt, m1_resp, m1_err;
    logic [1:0]  m1_width;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        dmem_req, dmem_cmd, dmem_resp, dmem_err;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        arb_busy, arb_spurious;

    rv3n_dmem_arb #(.DEPTH(DEPTH), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_width(m0_width),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_resp(m0_resp), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_width(m1_width),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_resp(m1_resp), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd),
        .dmem_width(dmem_width), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .dmem_err(dmem_err),
        .arb_busy(arb_busy), .arb_spurious(arb_spurious)
    );

    typedef struct {
        logic [31:0] addr;
        logic        cmd;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    int errors = 0;
    int checks = 0;

    mreq_t memq[$];
    exp_t  expq0[$];
    exp_t  expq1[$];
    int    outq[$];

    bit          mr[2];
    logic        mc[2];
    logic [1:0]  mw[2];
    logic [31:0] ma[2];
    logic [31:0] md[2];
    int          pct[2];
    int          last_m;
    bit          spur_m;
    bit          force_resp;
    int          lat;
    int          cyc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] memdata(input logic [31:0] a);
        if (a == 32'h100) return 32'h1111_1111;
        if (a == 32'h104) return 32'h2222_2222;
        return {a[15:0], a[15:0] ^ 16'hBEEF};
    endfunction

    function automatic logic memerr(input logic [31:0] a, input logic c);
        return (a[15:8] == 8'h02) && (c == CMD_WR);
    endfunction

    task automatic set_req(input int m, input logic c, input logic [31:0] a);
        mr[m] = 1'b1;
        mc[m] = c;
        mw[m] = W_WORD;
        ma[m] = a;
        md[m] = $urandom;
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            if (!mr[m] && ($urandom_range(0, 99) < pct[m]))
                set_req(m, logic'($urandom_range(0, 1)),
                        32'h100 + ($urandom_range(0, 127) << 2));
        end
        m0_req = mr[0]; m0_cmd = mc[0]; m0_width = mw[0];
        m0_addr = ma[0]; m0_wdata = md[0];
        m1_req = mr[1]; m1_cmd = mc[1]; m1_width = mw[1];
        m1_addr = ma[1]; m1_wdata = md[1];
        dmem_rdata = $urandom;
        dmem_err   = logic'($urandom_range(0, 1));
        dmem_resp  = 1'b0;
        if (force_resp) begin
            dmem_resp  = 1'b1;
            dmem_err   = 1'b0;
            force_resp = 1'b0;
        end else if (memq.size() > 0 && memq[0].due <= cyc) begin
            dmem_resp  = 1'b1;
            dmem_rdata = memdata(memq[0].addr);
            dmem_err   = memerr(memq[0].addr, memq[0].cmd);
        end
    endtask

    task automatic model_check();
        int  n;
        int  w;
        bit  pop;
        bit  space;
        bit  g;
        int  head;
        exp_t e;
        n     = outq.size();
        pop   = dmem_resp && (n != 0);
        space = (n < DEPTH) || pop;
        if (mr[0] && mr[1]) w = 1 - last_m;
        else                w = mr[1] ? 1 : 0;
        g     = (mr[0] || mr[1]) && space;
        head  = (n != 0) ? outq[0] : -1;
        chk("m0_gnt", 32'(m0_gnt), 32'(g && w == 0));
        chk("m1_gnt", 32'(m1_gnt), 32'(g && w == 1));
        chk("dmem_req", 32'(dmem_req), 32'(g));
        chk("dmem_cmd", 32'(dmem_cmd), g ? 32'(mc[w]) : 32'd0);
        chk("dmem_width", 32'(dmem_width), g ? 32'(mw[w]) : 32'd0);
        chk("dmem_addr", dmem_addr, g ? ma[w] : 32'd0);
        chk("dmem_wdata", dmem_wdata, g ? md[w] : 32'd0);
        chk("m0_resp", 32'(m0_resp), 32'(pop && head == 0));
        chk("m1_resp", 32'(m1_resp), 32'(pop && head == 1));
        chk("arb_busy", 32'(arb_busy), 32'(n != 0));
        chk("arb_spurious", 32'(arb_spurious), 32'(spur_m));
        if (dmem_resp && n == 0) spur_m = 1'b1;
        if (pop) void'(outq.pop_front());
        if (dmem_resp && memq.size() > 0) void'(memq.pop_front());
        if (dmem_req)
            memq.push_back('{dmem_addr, dmem_cmd, cyc + lat});
        if (g) begin
            e.data = memdata(ma[w]);
            e.err  = memerr(ma[w], mc[w]);
            outq.push_back(w);
            if (w == 0) expq0.push_back(e);
            else        expq1.push_back(e);
            last_m = w;
            mr[w]  = 1'b0;
        end
    endtask

    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            drive();
            @(negedge clk);
            model_check();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b1;
        mr[0] = 1'b0; mr[1] = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        dmem_resp = 1'b0; dmem_err = 1'b0;
        force_resp = 1'b0;
        @(negedge clk);
        memq.delete(); outq.delete();
        expq0.delete(); expq1.delete();
        last_m = 1;
        spur_m = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (m0_resp) begin
                if (expq0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m0_unexpected_resp @cyc %0d: got 1 expected 0", cyc);
                end else begin
                    e = expq0.pop_front();
                    chk("m0_rdata", m0_rdata, e.data);
                    chk("m0_err", 32'(m0_err), 32'(e.err));
                end
            end else begin
                chk("m0_rdata_idle", m0_rdata, 32'd0);
                chk("m0_err_idle", 32'(m0_err), 32'd0);
            end
            if (m1_resp) begin
                if (expq1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m1_unexpected_resp @cyc %0d: got 1 expected 0", cyc);
                end else begin
                    e = expq1.pop_front();
                    chk("m1_rdata", m1_rdata, e.data);
                    chk("m1_err", 32'(m1_err), 32'(e.err));
                end
            end else begin
                chk("m1_rdata_idle", m1_rdata, 32'd0);
                chk("m1_err_idle", 32'(m1_err), 32'd0);
            end
        end
    end

    initial begin
        cyc = 0; lat = 1; force_resp = 1'b0;
        pct[0] = 0; pct[1] = 0;
        for (int m = 0; m < 2; m++) begin
            mr[m] = 1'b0; mc[m] = 1'b0; mw[m] = 2'd0;
            ma[m] = '0; md[m] = '0;
        end
        rst = 1'b1;
        m0_req = 0; m0_cmd = 0; m0_width = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_cmd = 0; m1_width = 0; m1_addr = 0; m1_wdata = 0;
        dmem_rdata = 0; dmem_resp = 0; dmem_err = 0;
        do_reset();
        do_reset();
        step(2);

        // m0-only back-to-back reads
        set_req(0, CMD_RD, 32'h100);
        step(1);
        set_req(0, CMD_RD, 32'h104);
        step(4);

        // both masters every cycle: round-robin
        pct[0] = 100; pct[1] = 100;
        step(12);
        pct[0] = 0; pct[1] = 0;
        step(4);

        // long memory stall with both requesting
        lat = 6;
        pct[0] = 100; pct[1] = 100;
        step(10);
        pct[0] = 0; pct[1] = 0;
        lat = 1;
        step(12);

        // error response to m1 then a clean m0 read
        set_req(1, CMD_WR, 32'h200);
        step(1);
        set_req(0, CMD_RD, 32'h104);
        step(4);

        // spurious response
        force_resp = 1'b1;
        step(4);

        // reset with transactions outstanding
        lat = 4;
        pct[0] = 100; pct[1] = 100;
        step(3);
        pct[0] = 0; pct[1] = 0;
        do_reset();
        lat = 1;
        set_req(0, CMD_RD, 32'h100);
        set_req(1, CMD_RD, 32'h104);
        step(5);

        // random traffic
        pct[0] = 60; pct[1] = 60;
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 3);
            step(1);
        end
        pct[0] = 0; pct[1] = 0;
        lat = 1;
        step(15);

        if (expq0.size() != 0 || expq1.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d/%0d responses pending expected 0/0",
                     expq0.size(), expq1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
